// File: rtl/matrix_mac_pkg.sv
// Shared FSM state type, default parameters and width helper for the
// sequential matrix multiply-accumulate block.
package matrix_mac_pkg;

  localparam int unsigned DEF_N          = 32'd4;
  localparam int unsigned DEF_DATA_WIDTH = 32'd8;
  localparam int unsigned DEF_ACC_WIDTH  = 32'd32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Width at which an N-term dot product of unsigned operands cannot overflow.
  function automatic int unsigned dot_width(input int unsigned n, input int unsigned dw);
    return 32'd2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_mac_seq_if.sv
// Command/operand/result bundle of matrix_mac_seq; the slave modport is the
// design side, the master modport the requester side.
interface matrix_mac_seq_if
  import matrix_mac_pkg::*;
#(
  parameter int unsigned N          = DEF_N,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH
);

  logic                                      start;
  logic                                      accumulate;
  logic                                      clear;
  logic [N-1:0][N-1:0][DATA_WIDTH-1:0]       matrix_a;
  logic [N-1:0][N-1:0][DATA_WIDTH-1:0]       matrix_b;
  logic [N-1:0][N-1:0][ACC_WIDTH-1:0]        result;
  logic                                      busy;
  logic                                      done;
  logic                                      overflow;

  modport master (
    output start, accumulate, clear, matrix_a, matrix_b,
    input  result, busy, done, overflow
  );

  modport slave (
    input  start, accumulate, clear, matrix_a, matrix_b,
    output result, busy, done, overflow
  );

endinterface

// File: rtl/mac_dot_product.sv
// Combinational N-lane dot product of one row and one column, computed at
// full width so that no partial sum is ever truncated.
module mac_dot_product
  import matrix_mac_pkg::*;
#(
  parameter int unsigned N          = DEF_N,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  localparam int unsigned DOT_W     = dot_width(N, DATA_WIDTH)
) (
  input  logic [N-1:0][DATA_WIDTH-1:0] i_row,
  input  logic [N-1:0][DATA_WIDTH-1:0] i_col,
  output logic [DOT_W-1:0]             o_dot
);

  // Sum of the N lane products.
  always_comb begin
    o_dot = {DOT_W{1'b0}};
    for (int m = 0; m < N; m++) begin
      o_dot = o_dot + DOT_W'(i_row[m]) * DOT_W'(i_col[m]);
    end
  end

endmodule

// File: rtl/matrix_mac_seq.sv
// Sequential N x N matrix multiply-accumulate, one result element per cycle.
// Define MATRIX_MAC_SAT_EN to clamp overflowing elements instead of wrapping.
module matrix_mac_seq
  import matrix_mac_pkg::*;
#(
  parameter int unsigned N          = DEF_N,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic            i_clk,
  input  logic            i_reset,
  matrix_mac_seq_if.slave bus
);

  localparam int unsigned   DOT_W = dot_width(N, DATA_WIDTH);
  localparam int unsigned   IW    = $clog2(N);
  localparam int unsigned   SW    = ACC_WIDTH + 32'd1;
  localparam logic [IW-1:0] LAST  = IW'(N - 32'd1);

  state_e                                r_state;
  state_e                                w_next_state;
  logic [N-1:0][N-1:0][DATA_WIDTH-1:0]   r_a;
  logic [N-1:0][N-1:0][DATA_WIDTH-1:0]   r_b;
  logic                                  r_acc_mode;
  logic [IW-1:0]                         r_row;
  logic [IW-1:0]                         r_col;
  logic [N-1:0][N-1:0][ACC_WIDTH-1:0]    r_result;
  logic                                  r_overflow;
  logic                                  r_busy;
  logic                                  r_done;

  logic [N-1:0][DATA_WIDTH-1:0]          w_col;
  logic [DOT_W-1:0]                      w_dot;
  logic [SW-1:0]                         w_sum;
  logic                                  w_ovf;
  logic [ACC_WIDTH-1:0]                  w_new;
  logic                                  w_last;

  // Gather column r_col of the latched B operand.
  always_comb begin
    for (int m = 0; m < N; m++) begin
      w_col[m] = r_b[m][r_col];
    end
  end

  mac_dot_product #(
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_dot (
    .i_row (r_a[r_row]),
    .i_col (w_col),
    .o_dot (w_dot)
  );

  // New value for the current element; the extra sum bit exposes overflow.
  always_comb begin
    if (r_acc_mode) begin
      w_sum = {1'b0, r_result[r_row][r_col]} + SW'(w_dot);
    end else begin
      w_sum = SW'(w_dot);
    end
    w_ovf = w_sum[ACC_WIDTH];
`ifdef MATRIX_MAC_SAT_EN
    if (w_ovf) begin
      w_new = {ACC_WIDTH{1'b1}};
    end else begin
      w_new = w_sum[ACC_WIDTH-1:0];
    end
`else
    w_new = w_sum[ACC_WIDTH-1:0];
`endif
  end

  assign w_last = (r_row == LAST) && (r_col == LAST);

  // Next-state logic; clear in IDLE wins over a simultaneous start.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (bus.clear) begin
          w_next_state = IDLE;
        end else if (bus.start) begin
          w_next_state = COMPUTE;
        end else begin
          w_next_state = IDLE;
        end
      end
      COMPUTE: begin
        if (w_last) begin
          w_next_state = DONE;
        end else begin
          w_next_state = COMPUTE;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State, operand capture, element index and accumulator array.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_acc_mode <= 1'b0;
      r_row      <= {IW{1'b0}};
      r_col      <= {IW{1'b0}};
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state == COMPUTE) || (w_next_state == DONE);
      r_done  <= (w_next_state == DONE);
      case (r_state)
        IDLE: begin
          if (bus.clear) begin
            r_result   <= '0;
            r_overflow <= 1'b0;
          end else if (bus.start) begin
            r_a        <= bus.matrix_a;
            r_b        <= bus.matrix_b;
            r_acc_mode <= bus.accumulate;
            r_row      <= {IW{1'b0}};
            r_col      <= {IW{1'b0}};
          end
        end
        COMPUTE: begin
          r_result[r_row][r_col] <= w_new;
          if (w_ovf) begin
            r_overflow <= 1'b1;
          end
          if (r_col == LAST) begin
            r_col <= {IW{1'b0}};
            r_row <= r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        DONE: begin
          r_row <= {IW{1'b0}};
          r_col <= {IW{1'b0}};
        end
        default: begin
          r_row <= {IW{1'b0}};
          r_col <= {IW{1'b0}};
        end
      endcase
    end
  end

  assign bus.result   = r_result;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_matrix_mac_seq.sv
// Directed + randomized bench for matrix_mac_seq (N=4, DATA_WIDTH=8,
// ACC_WIDTH=20) against a plain matrix-arithmetic reference model.
module tb_matrix_mac_seq;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 20;
  localparam longint MAXV = (64'd1 << AW) - 64'd1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [DW-1:0] ta [N][N];
  logic [DW-1:0] tb [N][N];
  longint        m_res [N][N];
  bit            m_ovf;

  always #5 clk = ~clk;

  matrix_mac_seq_if #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus ();

  matrix_mac_seq #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check($sformatf("%s_res[%0d][%0d]", tag, i, j), 64'(bus.result[i][j]), 64'(m_res[i][j]));
    check({tag, "_ovf"}, 64'(bus.overflow), 64'(m_ovf));
  endtask

  // Reference: result = A*B or result + A*B, saturating or wrapping per build.
  task automatic model_pass(input bit acc);
    longint dot, s;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        dot = 0;
        for (int m = 0; m < N; m++) dot += longint'(ta[i][m]) * longint'(tb[m][j]);
        s = acc ? m_res[i][j] + dot : dot;
        if (s > MAXV) begin
          m_ovf = 1'b1;
`ifdef MATRIX_MAC_SAT_EN
          s = MAXV;
`else
          s = s % (MAXV + 64'd1);
`endif
        end
        m_res[i][j] = s;
      end
  endtask

  task automatic model_zero();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) m_res[i][j] = 0;
    m_ovf = 1'b0;
  endtask

  task automatic scramble_bus();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        bus.matrix_a[i][j] = DW'($urandom);
        bus.matrix_b[i][j] = DW'($urandom);
      end
  endtask

  task automatic random_ops();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ta[i][j] = DW'($urandom);
        tb[i][j] = DW'($urandom);
      end
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    model_zero();
  endtask

  // mode 0: plain pass; 1: start+clear pulsed at cycle 5; 2: reset at cycle 8.
  task automatic do_pass(input string tag, input bit acc, input int mode);
    int lat;
    bit seen;
    @(negedge clk);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        bus.matrix_a[i][j] = ta[i][j];
        bus.matrix_b[i][j] = tb[i][j];
      end
    bus.accumulate = acc;
    bus.start = 1'b1;
    @(posedge clk); #1;
    lat  = 1;
    seen = 1'b0;
    check({tag, "_busy_c1"}, 64'(bus.busy), 64'd1);
    while (!seen && lat < 40) begin
      @(negedge clk);
      scramble_bus();
      bus.accumulate = $urandom_range(0, 1);
      bus.start = (mode == 1 && lat == 5);
      bus.clear = (mode == 1 && lat == 5);
      reset     = (mode == 2 && lat == 8);
      @(posedge clk); #1;
      lat++;
      if (mode == 2 && lat == 9) break;
      if (bus.done) seen = 1'b1;
    end
    bus.start = 1'b0;
    bus.clear = 1'b0;
    if (mode == 2) begin
      @(negedge clk);
      reset = 1'b0;
      model_zero();
      check({tag, "_rst_busy"}, 64'(bus.busy), 64'd0);
      check({tag, "_rst_done"}, 64'(bus.done), 64'd0);
      check_state({tag, "_rst"});
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk); #1;
        if (bus.done || bus.busy) seen = 1'b1;
      end
      check({tag, "_no_done_after_rst"}, 64'(seen), 64'd0);
    end else begin
      check({tag, "_done_seen"}, 64'(seen), 64'd1);
      check({tag, "_latency"}, 64'(lat), 64'(N * N + 1));
      check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd1);
      model_pass(acc);
      check_state(tag);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
      check({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.clear = 1'b0;
    bus.accumulate = 1'b0;
    scramble_bus();
    model_zero();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check_state("reset");

    // Identity times B, then accumulate, then overwrite.
    do_clear();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ta[i][j] = (i == j) ? DW'(1) : DW'(0);
        tb[i][j] = DW'(4 * i + j);
      end
    do_pass("ident", 1'b0, 0);
    check("ident_const_3_2", 64'(bus.result[3][2]), 64'd14);
    do_pass("ident_acc", 1'b1, 0);
    check("ident_acc_const_2_3", 64'(bus.result[2][3]), 64'd22);
    do_pass("ident_again", 1'b0, 0);

    // Start/clear while busy are ignored.
    random_ops();
    do_pass("busy_ignore", 1'b1, 1);

    // Clear and start together in IDLE: clears, no pass.
    @(negedge clk);
    bus.clear = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    bus.start = 1'b0;
    model_zero();
    check("clr_start_busy", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    check("clr_start_busy2", 64'(bus.busy), 64'd0);
    check_state("clr_start");

    // Random operands, random accumulate mode.
    for (int p = 0; p < 4; p++) begin
      random_ops();
      do_pass($sformatf("rand%0d", p), 1'($urandom_range(0, 1)), 0);
    end

    // All-255 accumulate five times: overflow in a 20-bit accumulator.
    do_clear();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ta[i][j] = DW'(255);
        tb[i][j] = DW'(255);
      end
    for (int p = 0; p < 5; p++) do_pass($sformatf("ovf%0d", p), 1'b1, 0);
`ifdef MATRIX_MAC_SAT_EN
    check("ovf_const", 64'(bus.result[1][1]), 64'd1048575);
`else
    check("ovf_const", 64'(bus.result[1][1]), 64'd251924);
`endif
    check("ovf_flag_const", 64'(bus.overflow), 64'd1);
    do_clear();
    check_state("ovf_cleared");

    // Reset mid-pass, then a fresh pass completes normally.
    random_ops();
    do_pass("midreset", 1'b0, 2);
    random_ops();
    do_pass("post_reset", 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_mac_seq.md
MATRIX_MAC_SEQ -- requirements
Module: matrix_mac_seq

Interface
REQ-001 Parameter N, 4: matrix dimension (N x N); legal range 2..16.
REQ-002 Parameter DATA_WIDTH, 8: unsigned operand element width.
REQ-003 Parameter ACC_WIDTH, 32: unsigned result element width; SHALL be >= 2*DATA_WIDTH + clog2(N).
REQ-004 clock  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  request a new multiply pass; sampled only in IDLE.
REQ-007 accumulate  in  1  captured with start; 1 = result += A*B, 0 = result = A*B.
REQ-008 clear  in  1  zero result and overflow; honoured only in IDLE.
REQ-009 matrix_a  in  DATA_WIDTH x [N][N]  left operand, captured on start.
REQ-010 matrix_b  in  DATA_WIDTH x [N][N]  right operand, captured on start.
REQ-011 result  out  ACC_WIDTH x [N][N]  accumulator array, registered.
REQ-012 busy  out  1  high in COMPUTE and DONE.
REQ-013 done  out  1  single-cycle pulse when a pass completes.
REQ-014 overflow  out  1  sticky flag; any element exceeded 2^ACC_WIDTH-1.

Function
REQ-015 FSM states SHALL be IDLE, COMPUTE, DONE.
REQ-016 IDLE, clear=1: result and overflow zeroed next edge; start on the same cycle is dropped.
REQ-017 IDLE, start=1, clear=0: matrix_a, matrix_b and accumulate latched into internal registers; element index k <= 0; go to COMPUTE.
REQ-018 COMPUTE: one element per cycle, row-major, k = i*N + j; element dot = sum over m of a[i][m]*b[m][j] using N parallel multipliers.
REQ-019 Element update: result[i][j] <= dot (accumulate=0) or result[i][j] + dot (accumulate=1); all other elements hold.
REQ-020 After element k = N*N-1 is written, go to DONE; done=1 for exactly that one cycle, then IDLE.
REQ-021 Latency: done is high on the (N*N+1)th cycle after the start-sampling edge (17 for N=4); next start is accepted in the cycle after done.
REQ-022 start and clear while busy=1 SHALL be ignored; operand inputs may change freely while busy.
REQ-023 Arithmetic is unsigned; dot is computed at full width 2*DATA_WIDTH+clog2(N) with no loss.
REQ-024 overflow SHALL be set when an accumulate sum exceeds 2^ACC_WIDTH-1; it is cleared only by clear or reset.
REQ-025 result SHALL be readable at all times; intermediate values are visible during COMPUTE.

Reset
REQ-026 reset=1 SHALL force IDLE, result all zero, busy=0, done=0, overflow=0 at the next edge, including mid-pass (the pass is aborted and not resumed).
REQ-027 reset SHALL take priority over start and clear.

Configuration
REQ-028 Macro MATRIX_MAC_SAT_EN defined: an overflowing element update SHALL clamp to 2^ACC_WIDTH-1.
REQ-029 Macro MATRIX_MAC_SAT_EN undefined: an overflowing element update SHALL wrap modulo 2^ACC_WIDTH; overflow is flagged in both builds.

Structure
REQ-030 Package matrix_mac_pkg SHALL hold the FSM state typedef (IDLE/COMPUTE/DONE) and the default parameter constants.
REQ-031 Sub-module mac_dot_product (combinational, N lanes, parameters N and DATA_WIDTH) SHALL compute the row-by-column dot product; matrix_mac_seq holds the FSM, operand registers, index counter and accumulator.

Verification (N=4, DATA_WIDTH=8 unless stated)
REQ-032 After reset, clear; A=identity, B[i][j]=4*i+j, accumulate=0, start -> done on cycle 17, result=B, overflow=0.
REQ-033 Repeat the same pass with accumulate=1 -> result[i][j]=2*(4*i+j); a third pass with accumulate=0 -> result=B.
REQ-034 ACC_WIDTH=20, all operands 255, five accumulate passes (dot=260100) -> SAT_EN build: all elements 1048575, overflow=1; wrap build: all elements 251924, overflow=1.
REQ-035 start pulsed and clear pulsed at cycle 5 of a pass -> both ignored, done still on cycle 17, result correct; clear and start together in IDLE -> result zero, no pass started (busy stays 0).
REQ-036 reset asserted at cycle 8 of a pass -> next cycle IDLE, result all zero, busy=0, done never pulses; a new start then completes normally.
